jtframe_ddram_arb: RTL and testbench

- Two-requester burst arbiter for the MiSTer DDR3 Avalon-style port (29-bit 64-bit-word address, 64-bit data, 8-bit burst count).
- Requester A is the ROM download streamer reading from 0x3000_0000 and has priority.
- Requester B is a secondary client, such as an NVRAM/state dump or a rewind buffer.
- The block grants whole bursts, holds the grant until the last read beat returns or the last write beat is accepted, then re-arbitrates.

---
 rtl/jtframe_ddram_pkg.sv | 27 ++
 rtl/jtframe_ddram_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_jtframe_ddram_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_ddram_pkg.sv
// Shared definitions for the MiSTer DDR3 burst arbiter.
//   state_t    : arbiter FSM states
//   DDR_*      : DDR port geometry (word address, data and byte-enable widths)
//   OWN_A/B    : owner encoding for the current grant
//   norm_burst : maps a zero burst count to a single beat
package jtframe_ddram_pkg;

    localparam int DDR_AW  = 29;
    localparam int DDR_DW  = 64;
    localparam int DDR_BEW = 8;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_DATA,
        WR,
        DONE
    } state_t;

    function automatic logic [7:0] norm_burst(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/jtframe_ddram_arb.sv
// Two-requester burst arbiter in front of the MiSTer DDR3 Avalon-style port.
// Requester A (ROM download streamer) has priority; requester B gets a grant
// when A is idle or after STARVE consecutive A bursts while B waits.
// A grant covers a whole burst and is held until the last read beat returns
// or the last write beat is accepted.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   a_* / b_*               : requester side (rd, we, addr, burstcnt, din, be
//                             in; busy, dout_ready out)
//   x_dout                  : read data broadcast to both requesters
//   ddram_*                 : DDR side (busy, dout, dout_ready in; rd, we,
//                             addr, burstcnt, din, be out)
module jtframe_ddram_arb
    import jtframe_ddram_pkg::*;
#(
    parameter int STARVE = 4,
    parameter int AW     = DDR_AW,
    parameter int DW     = DDR_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // requester A
    input  logic                 a_rd,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic [7:0]           a_burstcnt,
    input  logic [DW-1:0]        a_din,
    input  logic [DDR_BEW-1:0]   a_be,
    output logic                 a_busy,
    output logic                 a_dout_ready,
    // requester B
    input  logic                 b_rd,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic [7:0]           b_burstcnt,
    input  logic [DW-1:0]        b_din,
    input  logic [DDR_BEW-1:0]   b_be,
    output logic                 b_busy,
    output logic                 b_dout_ready,
    // shared read data
    output logic [DW-1:0]        x_dout,
    // DDR port
    input  logic                 ddram_busy,
    output logic                 ddram_rd,
    output logic                 ddram_we,
    output logic [AW-1:0]        ddram_addr,
    output logic [7:0]           ddram_burstcnt,
    output logic [DW-1:0]        ddram_din,
    output logic [DDR_BEW-1:0]   ddram_be,
    input  logic [DW-1:0]        ddram_dout,
    input  logic                 ddram_dout_ready
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           len_q, len_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [7:0]           bcnt_q, bcnt_d;
    logic [SW-1:0]        starve_q, starve_d;

    logic                 a_req, b_req;
    logic                 own_rd, own_we;
    logic [AW-1:0]        own_addr;
    logic [7:0]           own_bcnt;
    logic [DW-1:0]        own_din;
    logic [DDR_BEW-1:0]   own_be;
    logic                 owner_busy;
    logic                 owner_dout_ready;

    assign a_req    = a_rd | a_we;
    assign b_req    = b_rd | b_we;

    assign own_rd   = (owner_q == OWN_B) ? b_rd : a_rd;
    assign own_we   = (owner_q == OWN_B) ? b_we : a_we;
    assign own_addr = (owner_q == OWN_B) ? b_addr : a_addr;
    assign own_bcnt = norm_burst((owner_q == OWN_B) ? b_burstcnt : a_burstcnt);
    assign own_din  = (owner_q == OWN_B) ? b_din : a_din;
    assign own_be   = (owner_q == OWN_B) ? b_be : a_be;

    assign x_dout   = ddram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_A;
            cnt_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            bcnt_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cnt_d            = cnt_q;
        len_d            = len_q;
        addr_d           = addr_q;
        bcnt_d           = bcnt_q;
        starve_d         = starve_q;

        ddram_rd         = 1'b0;
        ddram_we         = 1'b0;
        ddram_addr       = '0;
        ddram_burstcnt   = '0;
        ddram_din        = '0;
        ddram_be         = '0;
        owner_busy       = 1'b1;
        owner_dout_ready = 1'b0;

        // The starvation count only means something while B is waiting.
        if (!b_req) begin
            starve_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d = CMD;
                    if (b_req && (!a_req || starve_q >= STARVE_MAX)) begin
                        owner_d  = OWN_B;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_A;
                        if (b_req) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end

            CMD: begin
                // A simultaneous rd+we is treated as a read; we is masked so
                // the DDR never sees both commands in one cycle.
                ddram_rd       = own_rd;
                ddram_we       = own_we & ~own_rd;
                ddram_addr     = own_addr;
                ddram_burstcnt = own_bcnt;
                ddram_din      = own_din;
                ddram_be       = own_be;
                owner_busy     = ddram_busy;
                if (own_rd && !ddram_busy) begin
                    state_d = RD_DATA;
                    len_d   = own_bcnt;
                    cnt_d   = '0;
                    addr_d  = own_addr;
                    bcnt_d  = own_bcnt;
                end else if (own_we && !ddram_busy) begin
                    state_d = (own_bcnt == 8'd1) ? DONE : WR;
                    len_d   = own_bcnt;
                    cnt_d   = 8'd1;
                    addr_d  = own_addr;
                    bcnt_d  = own_bcnt;
                end else if (!own_rd && !own_we) begin
                    // Request withdrawn before the DDR took it.
                    state_d = IDLE;
                end
            end

            RD_DATA: begin
                if (ddram_dout_ready) begin
                    owner_dout_ready = 1'b1;
                    cnt_d            = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = DONE;
                    end
                end
            end

            WR: begin
                // Address and burst count were fixed by the first beat.
                ddram_we       = own_we;
                ddram_addr     = addr_q;
                ddram_burstcnt = bcnt_q;
                ddram_din      = own_din;
                ddram_be       = own_be;
                // Keep the owner stalled if it only presents a read mid-burst.
                owner_busy     = ddram_busy | ~own_we;
                if (own_we && !ddram_busy) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route the owner-facing handshake to the right requester.
    always_comb begin
        a_busy       = 1'b1;
        b_busy       = 1'b1;
        a_dout_ready = 1'b0;
        b_dout_ready = 1'b0;
        if (owner_q == OWN_B) begin
            b_busy       = owner_busy;
            b_dout_ready = owner_dout_ready;
        end else begin
            a_busy       = owner_busy;
            a_dout_ready = owner_dout_ready;
        end
    end

endmodule

// File: tb/tb_jtframe_ddram_arb.sv
// Directed testbench for jtframe_ddram_arb: a DDR responder model returns
// read beats with a programmable gap and can toggle waitrequest; each test
// task drives one scenario and checks its own results.
module tb_jtframe_ddram_arb;
    import jtframe_ddram_pkg::*;

    localparam int AW = 29;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_rd = 1'b0, a_we = 1'b0;
    logic [AW-1:0]   a_addr = '0;
    logic [7:0]      a_burstcnt = '0;
    logic [DW-1:0]   a_din = '0;
    logic [7:0]      a_be = '0;
    logic            a_busy, a_dout_ready;
    logic            b_rd = 1'b0, b_we = 1'b0;
    logic [AW-1:0]   b_addr = '0;
    logic [7:0]      b_burstcnt = '0;
    logic [DW-1:0]   b_din = '0;
    logic [7:0]      b_be = '0;
    logic            b_busy, b_dout_ready;
    logic [DW-1:0]   x_dout;
    logic            ddram_busy = 1'b0;
    logic            ddram_rd, ddram_we;
    logic [AW-1:0]   ddram_addr;
    logic [7:0]      ddram_burstcnt;
    logic [DW-1:0]   ddram_din;
    logic [7:0]      ddram_be;
    logic [DW-1:0]   ddram_dout = '0;
    logic            ddram_dout_ready;
    logic            rsp_beat = 1'b0;
    logic            stray_beat = 1'b0;

    assign ddram_dout_ready = rsp_beat | stray_beat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtframe_ddram_arb #(.STARVE(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_rd(a_rd), .a_we(a_we), .a_addr(a_addr), .a_burstcnt(a_burstcnt),
        .a_din(a_din), .a_be(a_be), .a_busy(a_busy), .a_dout_ready(a_dout_ready),
        .b_rd(b_rd), .b_we(b_we), .b_addr(b_addr), .b_burstcnt(b_burstcnt),
        .b_din(b_din), .b_be(b_be), .b_busy(b_busy), .b_dout_ready(b_dout_ready),
        .x_dout(x_dout),
        .ddram_busy(ddram_busy), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
        .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
        .ddram_din(ddram_din), .ddram_be(ddram_be),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready)
    );

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    int cnt_a_dr = 0, cnt_b_dr = 0, cnt_rd_acc = 0, rsp_added = 0;
    int wr_addr_bad = 0, wr_busy_bad = 0;
    logic [AW-1:0] mon_wr_addr = '0;
    logic [AW-1:0] acc_addr_q[$];
    logic [7:0]    acc_bcnt_q[$];
    logic [DW-1:0] wr_din_q[$];
    logic [7:0]    wr_be_q[$];
    logic [7:0]    wr_bcnt_q[$];

    always @(negedge clk) begin
        if (a_dout_ready) cnt_a_dr++;
        if (b_dout_ready) cnt_b_dr++;
        if (ddram_rd && !ddram_busy) begin
            cnt_rd_acc++;
            acc_addr_q.push_back(ddram_addr);
            acc_bcnt_q.push_back(ddram_burstcnt);
            rsp_added += int'(ddram_burstcnt);
        end
        if (ddram_we && !ddram_busy) begin
            wr_din_q.push_back(ddram_din);
            wr_be_q.push_back(ddram_be);
            wr_bcnt_q.push_back(ddram_burstcnt);
        end
        if (ddram_we) begin
            if (ddram_addr !== mon_wr_addr) wr_addr_bad++;
            if (b_busy !== ddram_busy) wr_busy_bad++;
            if (a_busy !== 1'b1) wr_busy_bad++;
        end
    end

    // DDR responder: returns accepted read beats, gap cycles apart.
    int  rsp_given = 0, gap_cnt = 0, rsp_gap = 0;
    bit  busy_toggle = 1'b0;

    always @(posedge clk) begin
        #1;
        rsp_beat = 1'b0;
        if (rsp_given < rsp_added) begin
            if (gap_cnt == 0) begin
                rsp_beat   = 1'b1;
                ddram_dout = {32'hD0D0_0000, 32'(rsp_given)};
                rsp_given++;
                gap_cnt    = rsp_gap;
            end else begin
                gap_cnt--;
            end
        end
        ddram_busy = busy_toggle ? ~ddram_busy : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input bit is_b, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            waited++;
            if (is_b ? ((b_rd | b_we) && !b_busy) : ((a_rd | a_we) && !a_busy)) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dut.state_q == IDLE && rsp_given == rsp_added) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_a_busy: got %0b want 1", a_busy); end
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL reset_b_busy: got %0b want 1", b_busy); end
        checks++; if (ddram_rd !== 1'b0) begin errors++; $display("FAIL reset_ddram_rd: got %0b want 0", ddram_rd); end
        checks++; if (ddram_we !== 1'b0) begin errors++; $display("FAIL reset_ddram_we: got %0b want 0", ddram_we); end
        checks++; if (ddram_addr !== '0) begin errors++; $display("FAIL reset_ddram_addr: got %0h want 0", ddram_addr); end
        checks++; if (ddram_burstcnt !== 8'd0) begin errors++; $display("FAIL reset_burstcnt: got %0d want 0", ddram_burstcnt); end
        checks++; if ({a_dout_ready, b_dout_ready} !== 2'b00) begin errors++; $display("FAIL reset_dout_ready: got %b want 00", {a_dout_ready, b_dout_ready}); end
        rst_n = 1'b1;
        tick();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_long_read();
        int  a0 = cnt_a_dr, b0 = cnt_b_dr, r0 = cnt_rd_acc, q0 = acc_addr_q.size();
        int  waited;
        bit  ok;
        rsp_gap    = 3;
        a_addr     = 29'h1800_0000;
        a_burstcnt = 8'd128;
        a_rd       = 1'b1;
        wait_accept(1'b0, waited, ok);
        a_rd = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL long_read_accept: timed out, want accept"); end
        checks++; if (waited !== 2) begin errors++; $display("FAIL long_read_latency: got %0d cycles want 2", waited); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL long_read_idle: timed out, want IDLE"); end
        checks++; if (cnt_a_dr - a0 !== 128) begin errors++; $display("FAIL long_read_a_beats: got %0d want 128", cnt_a_dr - a0); end
        checks++; if (cnt_b_dr - b0 !== 0) begin errors++; $display("FAIL long_read_b_beats: got %0d want 0", cnt_b_dr - b0); end
        checks++; if (cnt_rd_acc - r0 !== 1) begin errors++; $display("FAIL long_read_rd_cmds: got %0d want 1", cnt_rd_acc - r0); end
        if (acc_addr_q.size() > q0) begin
            checks++; if (acc_addr_q[q0] !== 29'h1800_0000) begin errors++; $display("FAIL long_read_addr: got %0h want 18000000", acc_addr_q[q0]); end
            checks++; if (acc_bcnt_q[q0] !== 8'd128) begin errors++; $display("FAIL long_read_bcnt: got %0d want 128", acc_bcnt_q[q0]); end
        end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL long_read_end_state: got %0d want IDLE", dut.state_q); end
        $display("test_long_read: A burst of 128 at 18000000, %0d beats", cnt_a_dr - a0);
    endtask

    task automatic test_simultaneous();
        int a0 = cnt_a_dr, b0 = cnt_b_dr;
        int order_a = -1, order_b = -1, n = 0;
        logic [AW-1:0] b_seen = '0;
        bit ok;
        rsp_gap    = 1;
        a_addr     = 29'h0000_0100;
        b_addr     = 29'h0ABC_DEF0;
        a_burstcnt = 8'd1;
        b_burstcnt = 8'd1;
        a_rd = 1'b1;
        b_rd = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (a_rd && !a_busy) begin order_a = n; n++; end
            if (b_rd && !b_busy) begin order_b = n; n++; b_seen = ddram_addr; end
            tick();
            if (order_a >= 0) a_rd = 1'b0;
            if (order_b >= 0) b_rd = 1'b0;
            if (order_a >= 0 && order_b >= 0) break;
        end
        a_rd = 1'b0;
        b_rd = 1'b0;
        wait_idle(ok);
        checks++; if (order_a !== 0) begin errors++; $display("FAIL simul_a_first: got order %0d want 0", order_a); end
        checks++; if (order_b !== 1) begin errors++; $display("FAIL simul_b_second: got order %0d want 1", order_b); end
        checks++; if (b_seen !== 29'h0ABC_DEF0) begin errors++; $display("FAIL simul_b_addr: got %0h want abcdef0", b_seen); end
        checks++; if (cnt_a_dr - a0 !== 1) begin errors++; $display("FAIL simul_a_beats: got %0d want 1", cnt_a_dr - a0); end
        checks++; if (cnt_b_dr - b0 !== 1) begin errors++; $display("FAIL simul_b_beats: got %0d want 1", cnt_b_dr - b0); end
        $display("test_simultaneous: A order %0d, B order %0d", order_a, order_b);
    endtask

    task automatic test_starvation();
        int seq[8];
        int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
        int n = 0;
        bit ok;
        rsp_gap    = 0;
        a_addr     = 29'h0000_1000;
        b_addr     = 29'h0000_2000;
        a_burstcnt = 8'd1;
        b_burstcnt = 8'd1;
        a_rd = 1'b1;
        b_rd = 1'b1;
        for (int i = 0; i < 1000 && n < 6; i++) begin
            @(negedge clk);
            if (ddram_rd && !ddram_busy) begin
                seq[n] = (ddram_addr == 29'h0000_2000) ? 1 : 0;
                n++;
            end
            tick();
            if (n > 0 && seq[n-1] == 1) b_rd = 1'b0;
        end
        a_rd = 1'b0;
        b_rd = 1'b0;
        wait_idle(ok);
        checks++; if (n !== 6) begin errors++; $display("FAIL starve_count: got %0d bursts want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got owner %0d want %0d", i, seq[i], exp_seq[i]);
            end
        end
        $display("test_starvation: %0d bursts granted", n);
    endtask

    task automatic test_b_write();
        int w0 = wr_din_q.size(), ab0 = wr_addr_bad, bb0 = wr_busy_bad;
        int waited;
        bit ok, all_ok = 1'b1;
        b_addr      = 29'h0123_4560;
        b_burstcnt  = 8'd4;
        mon_wr_addr = 29'h0123_4560;
        busy_toggle = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            b_din = 64'hBEEF_0000_0000_0000 | 64'(beat);
            b_be  = 8'(8'h81 + beat);
            b_we  = 1'b1;
            wait_accept(1'b1, waited, ok);
            if (!ok) begin all_ok = 1'b0; break; end
        end
        b_we = 1'b0;
        busy_toggle = 1'b0;
        wait_idle(ok);
        checks++; if (!all_ok) begin errors++; $display("FAIL write_accept: timed out, want 4 beats accepted"); end
        checks++; if (wr_din_q.size() - w0 !== 4) begin errors++; $display("FAIL write_beats: got %0d want 4", wr_din_q.size() - w0); end
        for (int i = 0; i < 4 && w0 + i < wr_din_q.size(); i++) begin
            checks++;
            if (wr_din_q[w0+i] !== (64'hBEEF_0000_0000_0000 | 64'(i))) begin
                errors++; $display("FAIL write_din[%0d]: got %0h want %0h", i, wr_din_q[w0+i], 64'hBEEF_0000_0000_0000 | 64'(i));
            end
            checks++;
            if (wr_be_q[w0+i] !== 8'(8'h81 + i)) begin
                errors++; $display("FAIL write_be[%0d]: got %0h want %0h", i, wr_be_q[w0+i], 8'(8'h81 + i));
            end
            checks++;
            if (wr_bcnt_q[w0+i] !== 8'd4) begin
                errors++; $display("FAIL write_bcnt[%0d]: got %0d want 4", i, wr_bcnt_q[w0+i]);
            end
        end
        checks++; if (wr_addr_bad - ab0 !== 0) begin errors++; $display("FAIL write_addr_hold: got %0d bad cycles want 0", wr_addr_bad - ab0); end
        checks++; if (wr_busy_bad - bb0 !== 0) begin errors++; $display("FAIL write_busy_mirror: got %0d bad cycles want 0", wr_busy_bad - bb0); end
        $display("test_b_write: B burst of 4 to 1234560, %0d beats", wr_din_q.size() - w0);
    endtask

    task automatic test_stray();
        stray_beat = 1'b1;
        @(negedge clk);
        checks++; if ({a_dout_ready, b_dout_ready} !== 2'b00) begin errors++; $display("FAIL stray_forward: got %b want 00", {a_dout_ready, b_dout_ready}); end
        checks++; if (x_dout !== ddram_dout) begin errors++; $display("FAIL x_dout_pass: got %0h want %0h", x_dout, ddram_dout); end
        tick();
        stray_beat = 1'b0;
        tick();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL stray_state: got %0d want IDLE", dut.state_q); end
        $display("test_stray: stray beat in IDLE");
    endtask

    task automatic test_burst_zero();
        int a0 = cnt_a_dr, q0 = acc_bcnt_q.size();
        int waited;
        bit ok;
        rsp_gap    = 0;
        a_addr     = 29'h0000_0040;
        a_burstcnt = 8'd0;
        a_rd       = 1'b1;
        wait_accept(1'b0, waited, ok);
        a_rd = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst0_idle: timed out, want IDLE"); end
        checks++; if (acc_bcnt_q.size() <= q0 || acc_bcnt_q[q0] !== 8'd1) begin
            errors++; $display("FAIL burst0_bcnt: got %0d want 1", (acc_bcnt_q.size() > q0) ? int'(acc_bcnt_q[q0]) : -1);
        end
        checks++; if (cnt_a_dr - a0 !== 1) begin errors++; $display("FAIL burst0_beats: got %0d want 1", cnt_a_dr - a0); end
        $display("test_burst_zero: A burst count 0 at 40");
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, a_snap, b_snap;
        int waited;
        bit ok;
        rsp_gap    = 0;
        a_addr     = 29'h1800_0000;
        a_burstcnt = 8'd128;
        a_rd       = 1'b1;
        wait_accept(1'b0, waited, ok);
        a_rd = 1'b0;
        for (int i = 0; i < 500 && n < 50; i++) begin
            @(negedge clk);
            if (a_dout_ready) n++;
        end
        checks++; if (n !== 50) begin errors++; $display("FAIL rst_mid_progress: got %0d beats want 50", n); end
        rst_n = 1'b0;
        #1;
        a_snap = cnt_a_dr;
        b_snap = cnt_b_dr;
        checks++; if ({a_busy, b_busy} !== 2'b11) begin errors++; $display("FAIL rst_mid_busy: got %b want 11", {a_busy, b_busy}); end
        checks++; if ({ddram_rd, ddram_we} !== 2'b00) begin errors++; $display("FAIL rst_mid_cmd: got %b want 00", {ddram_rd, ddram_we}); end
        checks++; if (a_dout_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_dout_ready: got %0b want 0", a_dout_ready); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want IDLE", dut.state_q); end
        repeat (2) tick();
        rst_n = 1'b1;
        wait_idle(ok);
        repeat (2) tick();
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_drain: timed out, want beats drained"); end
        checks++; if (cnt_a_dr !== a_snap) begin errors++; $display("FAIL rst_mid_a_after: got %0d beats want %0d", cnt_a_dr, a_snap); end
        checks++; if (cnt_b_dr !== b_snap) begin errors++; $display("FAIL rst_mid_b_after: got %0d beats want %0d", cnt_b_dr, b_snap); end
        $display("test_reset_mid_burst: reset after %0d of 128 beats", n);
    endtask

    initial begin
        test_reset();
        test_long_read();
        test_simultaneous();
        test_starvation();
        test_b_write();
        test_stray();
        test_burst_zero();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
